ex_operand_stage: RTL and testbench

ID/EX pipeline stage that sits directly upstream of the ALU. It registers decoded operands and control from the decode stage, and supports stall (hold) and flush (bubble). Each cycle it resolves data hazards by forwarding from the EX/MEM and MEM/WB results. It then drives the ALU's `a`, `b` and `alu_ctrl` inputs, and flags load-use hazards back to the hazard unit.

---
 rtl/ex_operand_stage.sv | 126 ++++++++++++
 tb/tb_ex_operand_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: registers decoded operands and control, then forwards
// EX/MEM and MEM/WB results into the ALU operands and detects load-use hazards.
module ex_operand_stage #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned REG_BITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic                stall,
    input  logic                flush,
    input  logic [WIDTH-1:0]    id_rs_data,
    input  logic [WIDTH-1:0]    id_rt_data,
    input  logic [15:0]         id_imm16,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic [1:0]          id_alu_ctrl,
    input  logic                id_alu_src,
    input  logic                id_reg_dst,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic                id_mem_to_reg,
    input  logic                mem_reg_write,
    input  logic [REG_BITS-1:0] mem_rd,
    input  logic [WIDTH-1:0]    mem_result,
    input  logic                wb_reg_write,
    input  logic [REG_BITS-1:0] wb_rd,
    input  logic [WIDTH-1:0]    wb_result,
    output logic                ex_valid,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [1:0]          alu_ctrl,
    output logic [WIDTH-1:0]    ex_store_data,
    output logic [REG_BITS-1:0] ex_dst,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                ex_mem_to_reg,
    output logic                load_use_hazard
);

    logic [WIDTH-1:0]    rs_data_q;
    logic [WIDTH-1:0]    rt_data_q;
    logic [WIDTH-1:0]    sext_imm_q;
    logic [REG_BITS-1:0] rs_q;
    logic [REG_BITS-1:0] rt_q;
    logic                alu_src_q;
    logic [WIDTH-1:0]    fwd_a;
    logic [WIDTH-1:0]    fwd_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            sext_imm_q    <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            alu_src_q     <= 1'b0;
            alu_ctrl      <= '0;
            ex_dst        <= '0;
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
        end else if (flush) begin
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            sext_imm_q    <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            alu_src_q     <= 1'b0;
            alu_ctrl      <= '0;
            ex_dst        <= '0;
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
        end else if (!stall) begin
            rs_data_q     <= id_rs_data;
            rt_data_q     <= id_rt_data;
            sext_imm_q    <= {{(WIDTH-16){id_imm16[15]}}, id_imm16};
            rs_q          <= id_rs;
            rt_q          <= id_rt;
            alu_src_q     <= id_alu_src;
            alu_ctrl      <= id_alu_ctrl;
            ex_dst        <= id_reg_dst ? id_rd : id_rt;
            ex_valid      <= id_valid;
            // An invalid decode slot still loads data but becomes a bubble.
            ex_reg_write  <= id_valid & id_reg_write;
            ex_mem_read   <= id_valid & id_mem_read;
            ex_mem_write  <= id_valid & id_mem_write;
            ex_mem_to_reg <= id_valid & id_mem_to_reg;
        end
    end

    // EX/MEM is younger than MEM/WB, so it wins; r0 is never forwarded.
    always_comb begin
        fwd_a = rs_data_q;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs_q)) begin
            fwd_a = mem_result;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs_q)) begin
            fwd_a = wb_result;
        end
    end

    always_comb begin
        fwd_b = rt_data_q;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == rt_q)) begin
            fwd_b = mem_result;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rt_q)) begin
            fwd_b = wb_result;
        end
    end

    assign alu_a         = fwd_a;
    assign alu_b         = alu_src_q ? sext_imm_q : fwd_b;
    assign ex_store_data = fwd_b;

    assign load_use_hazard = ex_valid && ex_mem_read && (ex_dst != '0) && id_valid &&
                             ((ex_dst == id_rs) || (ex_dst == id_rt));

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: stimulus queues expected outputs,
// a monitor pops and compares them on each falling clock edge.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, stall, flush;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm16;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [1:0]  id_alu_ctrl;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        mem_reg_write, wb_reg_write;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_result, wb_result;
    logic        ex_valid;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [1:0]  alu_ctrl;
    logic [4:0]  ex_dst;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_hazard;

    ex_operand_stage #(.WIDTH(32), .REG_BITS(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .stall(stall), .flush(flush),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm16(id_imm16),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_ctrl(id_alu_ctrl),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .ex_store_data(ex_store_data), .ex_dst(ex_dst), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .load_use_hazard(load_use_hazard)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        v;
        logic [31:0] a, b;
        logic [1:0]  c;
        logic [31:0] sd;
        logic [4:0]  d;
        logic        rw, mr, mw, m2r, luh;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic exp_t mk(string n, logic v, logic [31:0] a, logic [31:0] b, logic [1:0] c,
                                logic [31:0] sd, logic [4:0] d, logic rw, logic mr, logic mw,
                                logic m2r, logic luh);
        exp_t e;
        e.name = n; e.v = v; e.a = a; e.b = b; e.c = c; e.sd = sd; e.d = d;
        e.rw = rw; e.mr = mr; e.mw = mw; e.m2r = m2r; e.luh = luh;
        return e;
    endfunction

    task automatic cmp(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s.%s: got 0x%08h, required 0x%08h", nm, field, act, exp);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp(e.name, "ex_valid",        32'(ex_valid),        32'(e.v));
                cmp(e.name, "alu_a",           alu_a,                e.a);
                cmp(e.name, "alu_b",           alu_b,                e.b);
                cmp(e.name, "alu_ctrl",        32'(alu_ctrl),        32'(e.c));
                cmp(e.name, "ex_store_data",   ex_store_data,        e.sd);
                cmp(e.name, "ex_dst",          32'(ex_dst),          32'(e.d));
                cmp(e.name, "ex_reg_write",    32'(ex_reg_write),    32'(e.rw));
                cmp(e.name, "ex_mem_read",     32'(ex_mem_read),     32'(e.mr));
                cmp(e.name, "ex_mem_write",    32'(ex_mem_write),    32'(e.mw));
                cmp(e.name, "ex_mem_to_reg",   32'(ex_mem_to_reg),   32'(e.m2r));
                cmp(e.name, "load_use_hazard", 32'(load_use_hazard), 32'(e.luh));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input exp_t e);
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        // Inputs active while reset is held; r0 destinations must not forward.
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        id_valid = 1'b1; id_rs_data = 32'd8; id_rt_data = 32'd41; id_imm16 = 16'h0000;
        id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd7; id_alu_ctrl = 2'b11;
        id_alu_src = 1'b0; id_reg_dst = 1'b1; id_reg_write = 1'b1;
        id_mem_read = 1'b0; id_mem_write = 1'b0; id_mem_to_reg = 1'b0;
        mem_reg_write = 1'b1; mem_rd = 5'd0; mem_result = 32'hDEAD_BEEF;
        wb_reg_write = 1'b1;  wb_rd = 5'd0;  wb_result = 32'hCAFE_F00D;
        #1;
        expect_now(mk("reset_init", 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));

        rst_n = 1'b1;
        step();
        expect_now(mk("cap_sub", 1, 32'd8, 32'd41, 2'b11, 32'd41, 5'd7, 1, 0, 0, 0, 0));

        id_alu_src = 1'b1; id_imm16 = 16'hFFFE; id_reg_dst = 1'b0;
        step();
        expect_now(mk("cap_imm", 1, 32'd8, 32'hFFFF_FFFE, 2'b11, 32'd41, 5'd2, 1, 0, 0, 0, 0));

        id_valid = 1'b0; id_mem_read = 1'b1; id_mem_write = 1'b1; id_mem_to_reg = 1'b1;
        id_rs_data = 32'd77; id_alu_src = 1'b0;
        step();
        expect_now(mk("bubble", 0, 32'd77, 32'd41, 2'b11, 32'd41, 5'd2, 0, 0, 0, 0, 0));

        // Load a valid load with a pending hazard, then reset between edges.
        id_valid = 1'b1;
        step();
        rst_n = 1'b0;
        expect_now(mk("reset_mid", 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        id_mem_read = 1'b0; id_mem_write = 1'b0; id_mem_to_reg = 1'b0;
        id_rs = 5'd3; id_rt = 5'd4; id_rs_data = 32'd11; id_rt_data = 32'd22;
        id_alu_ctrl = 2'b10; id_reg_dst = 1'b1; id_rd = 5'd9;
        mem_reg_write = 1'b0; wb_reg_write = 1'b0;
        step();
        stall = 1'b1;
        mem_reg_write = 1'b1; mem_rd = 5'd3; mem_result = 32'd100;
        wb_reg_write = 1'b1;  wb_rd = 5'd3;  wb_result = 32'd200;
        expect_now(mk("fwd_mem", 1, 32'd100, 32'd22, 2'b10, 32'd22, 5'd9, 1, 0, 0, 0, 0));
        mem_reg_write = 1'b0;
        expect_now(mk("fwd_wb", 1, 32'd200, 32'd22, 2'b10, 32'd22, 5'd9, 1, 0, 0, 0, 0));
        mem_reg_write = 1'b1; mem_rd = 5'd0;
        expect_now(mk("fwd_mem_r0", 1, 32'd200, 32'd22, 2'b10, 32'd22, 5'd9, 1, 0, 0, 0, 0));
        wb_rd = 5'd0;
        expect_now(mk("fwd_all_r0", 1, 32'd11, 32'd22, 2'b10, 32'd22, 5'd9, 1, 0, 0, 0, 0));
        mem_rd = 5'd4; mem_result = 32'd300;
        expect_now(mk("fwd_b_mem", 1, 32'd11, 32'd300, 2'b10, 32'd300, 5'd9, 1, 0, 0, 0, 0));
        mem_reg_write = 1'b0; wb_rd = 5'd4;
        expect_now(mk("fwd_b_wb", 1, 32'd11, 32'd200, 2'b10, 32'd200, 5'd9, 1, 0, 0, 0, 0));

        wb_reg_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            id_rs_data = 32'(1000 + i); id_rt_data = 32'(2000 + i);
            id_valid = i[0]; id_alu_ctrl = i[1:0]; id_rd = 5'(20 + i);
            id_mem_write = 1'b1; id_alu_src = 1'b1;
            expect_now(mk($sformatf("stall_%0d", i), 1, 32'd11, 32'd22, 2'b10, 32'd22, 5'd9,
                          1, 0, 0, 0, 0));
        end

        stall = 1'b0;
        id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd5; id_reg_dst = 1'b0;
        id_mem_read = 1'b1; id_mem_write = 1'b0; id_reg_write = 1'b1; id_mem_to_reg = 1'b1;
        id_alu_src = 1'b1; id_imm16 = 16'h0010; id_rs_data = 32'h1000; id_rt_data = 32'h55;
        id_alu_ctrl = 2'b10;
        step();
        stall = 1'b1; id_rs = 5'd2; id_rt = 5'd5;
        expect_now(mk("luh_rt", 1, 32'h1000, 32'h10, 2'b10, 32'h55, 5'd5, 1, 1, 0, 1, 1));
        id_rt = 5'd6;
        expect_now(mk("luh_miss", 1, 32'h1000, 32'h10, 2'b10, 32'h55, 5'd5, 1, 1, 0, 1, 0));
        id_rs = 5'd5;
        expect_now(mk("luh_rs", 1, 32'h1000, 32'h10, 2'b10, 32'h55, 5'd5, 1, 1, 0, 1, 1));
        id_valid = 1'b0;
        expect_now(mk("luh_id_invalid", 1, 32'h1000, 32'h10, 2'b10, 32'h55, 5'd5, 1, 1, 0, 1, 0));

        stall = 1'b0;
        id_valid = 1'b1; id_mem_read = 1'b0; id_mem_to_reg = 1'b0; id_mem_write = 1'b1;
        id_reg_write = 1'b1; id_alu_src = 1'b1; id_imm16 = 16'h8000;
        id_rs = 5'd6; id_rt = 5'd7; id_rs_data = 32'd20; id_rt_data = 32'd30;
        id_alu_ctrl = 2'b00; id_reg_dst = 1'b1; id_rd = 5'd8;
        step();
        expect_now(mk("store", 1, 32'd20, 32'hFFFF_8000, 2'b00, 32'd30, 5'd8, 1, 0, 1, 0, 0));

        stall = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        expect_now(mk("stall_flush", 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
